// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the parametrised register file.
//   clog2_min1 : address width for a given depth, never below 1 bit
//   ZERO_IDX   : index of the optional hardwired-zero entry
//   RF_SLICE   : picks field idx (w bits wide) out of a packed multi-port bus
`ifndef RF_SLICE
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package regfile_pkg;

   localparam int ZERO_IDX = 0;

   // $clog2(2) is 1 but $clog2(1) is 0; clamp so a tiny file still has an address bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/register_param.sv
// register_param
//   One WIDTH-bit storage word.
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset, clears q
//   clr     : synchronous clear, wins over wr_en
//   wr_en   : load wr_data at the edge
//   wr_data : data to store
//   q       : stored word
module register_param #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (wr_en) begin
         q <= wr_data;
      end
   end

endmodule

// File: rtl/register_file_param.sv
// register_file_param
//   DEPTH x WIDTH register file, one write port, NUM_RD registered read ports
//   with write-first bypass, optional hardwired-zero entry 0, synchronous clear.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   clr      : synchronous clear of every entry (drops a concurrent write)
//   wr_en    : write enable
//   wr_addr  : write address (AW bits)
//   wr_data  : write data
//   rd_en    : per-port read enable
//   rd_addr  : packed read addresses, port i at [i*AW +: AW]
//   rd_data  : packed registered read data, port i at [i*WIDTH +: WIDTH]
//   rd_valid : per-port flag, high the cycle after an enabled read
//   wr_err   : high for one cycle after an out-of-range write attempt
module register_file_param
   import regfile_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int AW       = clog2_min1(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_addr,
   input  logic [WIDTH-1:0]        wr_data,
   input  logic [NUM_RD-1:0]       rd_en,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]       rd_valid,
   output logic                    wr_err
);

   // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] ZERO_A  = AW'(ZERO_IDX);

   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_in_range;
   logic             wr_zero_drop;
   logic             wr_commit;

   assign wr_in_range  = {1'b0, wr_addr} < DEPTH_W;
   assign wr_zero_drop = (ZERO_REG != 0) && (wr_addr == ZERO_A);
   // A write that will actually land in storage this edge; also the bypass qualifier.
   assign wr_commit    = wr_en && wr_in_range && !wr_zero_drop && !clr;

   for (genvar e = 0; e < DEPTH; e++) begin : g_word
      if ((ZERO_REG != 0) && (e == ZERO_IDX)) begin : g_zero
         assign mem[e] = '0;
      end else begin : g_reg
         register_param #(.WIDTH(WIDTH)) u_word (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .wr_en   (wr_commit && (wr_addr == AW'(e))),
            .wr_data (wr_data),
            .q       (mem[e])
         );
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data_d;
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      assign addr = `RF_SLICE(rd_addr, p, AW);

      always_comb begin
         data_d = '0;
         if (clr || ({1'b0, addr} >= DEPTH_W)) begin
            data_d = '0;
         end else if ((ZERO_REG != 0) && (addr == ZERO_A)) begin
            data_d = '0;
         end else if (wr_commit && (wr_addr == addr)) begin
            data_d = wr_data;
         end else begin
            data_d = mem[addr];
         end
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_en[p];
            if (rd_en[p]) begin
               data_q <= data_d;
            end
         end
      end

      assign `RF_SLICE(rd_data, p, WIDTH) = data_q;
      assign rd_valid[p] = valid_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && !wr_in_range;
      end
   end

endmodule

// File: tb/tb_register_file_param.sv
module tb_register_file_param;

   localparam int WIDTH  = 16;
   localparam int DEPTH  = 6;
   localparam int NUM_RD = 2;
   localparam int AW     = 3;

   logic                    clk;
   logic                    rst;
   logic                    clr;
   logic                    wr_en;
   logic [AW-1:0]           wr_addr;
   logic [WIDTH-1:0]        wr_data;
   logic [NUM_RD-1:0]       rd_en;
   logic [NUM_RD*AW-1:0]    rd_addr;
   logic [NUM_RD*WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]       rd_valid;
   logic                    wr_err;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [WIDTH-1:0] exp_mem  [DEPTH];
   logic [WIDTH-1:0] exp_data [NUM_RD];
   logic [NUM_RD-1:0] exp_valid;
   logic             exp_err;

   register_file_param #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .wr_err   (wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: reads see pre-edge storage except a same-cycle landing write.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int e = 0; e < DEPTH; e++) exp_mem[e] = '0;
         for (int i = 0; i < NUM_RD; i++) exp_data[i] = '0;
         exp_valid = '0;
         exp_err   = 1'b0;
      end else begin
         for (int i = 0; i < NUM_RD; i++) begin
            int a;
            a = int'((rd_addr >> (AW*i)) & 6'h7);
            if (rd_en[i]) begin
               if (clr || a >= DEPTH || a == 0)
                  exp_data[i] = '0;
               else if (wr_en && int'(wr_addr) == a)
                  exp_data[i] = wr_data;
               else
                  exp_data[i] = exp_mem[a];
            end
            exp_valid[i] = rd_en[i];
         end
         exp_err = wr_en && (int'(wr_addr) >= DEPTH);
         if (clr) begin
            for (int e = 0; e < DEPTH; e++) exp_mem[e] = '0;
         end else if (wr_en && int'(wr_addr) < DEPTH && wr_addr != 0) begin
            exp_mem[wr_addr] = wr_data;
         end
      end
   end

   // Per-cycle comparison against the model, away from the clock edge.
   always @(posedge clk) begin
      #2;
      check("cyc rd_data0",  32'(rd_data[15:0]),  32'(exp_data[0]));
      check("cyc rd_data1",  32'(rd_data[31:16]), 32'(exp_data[1]));
      check("cyc rd_valid",  32'(rd_valid),       32'(exp_valid));
      check("cyc wr_err",    32'(wr_err),         32'(exp_err));
   end

   task automatic idle();
      clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = '0; rd_addr = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; cyc();
   endtask

   task automatic do_read0(input logic [AW-1:0] a);
      idle(); rd_en = 2'b01; rd_addr = {3'd0, a}; cyc();
   endtask

   initial begin
      logic [WIDTH-1:0] tbl [DEPTH];
      rst = 1'b0;
      idle();
      @(negedge clk);
      cyc();
      check("reset rd_data", 32'(rd_data), 32'h0);
      check("reset rd_valid", 32'(rd_valid), 32'h0);
      check("reset wr_err", 32'(wr_err), 32'h0);

      // Async reset mid-run
      rst = 1'b1;
      do_write(3'd3, 16'h1234);
      idle(); wr_en = 1'b1; wr_addr = 3'd7; rd_en = 2'b01; rd_addr = {3'd0, 3'd3}; cyc();
      check("pre-rst rd_data0", 32'(rd_data[15:0]), 32'h1234);
      check("pre-rst wr_err", 32'(wr_err), 32'h1);
      idle();
      #2 rst = 1'b0;
      #1;
      check("async rst rd_data0", 32'(rd_data[15:0]), 32'h0);
      check("async rst wr_err", 32'(wr_err), 32'h0);
      check("async rst rd_valid", 32'(rd_valid), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      idle(); rd_en = 2'b11; rd_addr = {3'd3, 3'd3}; cyc();
      check("post-rst addr3", 32'(rd_data), 32'h0);
      check("post-rst valid", 32'(rd_valid), 32'h3);

      // Write then read, then hold
      do_write(3'd5, 16'hBEEF);
      do_read0(3'd5);
      check("wr/rd data0", 32'(rd_data[15:0]), 32'hBEEF);
      check("wr/rd valid0", 32'(rd_valid[0]), 32'h1);
      idle(); cyc();
      check("hold data0", 32'(rd_data[15:0]), 32'hBEEF);
      check("hold valid0", 32'(rd_valid[0]), 32'h0);

      // Bypass on both ports
      do_write(3'd2, 16'h0001);
      idle(); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hA5A5;
      rd_en = 2'b11; rd_addr = {3'd2, 3'd2}; cyc();
      check("bypass port0", 32'(rd_data[15:0]), 32'hA5A5);
      check("bypass port1", 32'(rd_data[31:16]), 32'hA5A5);

      // Zero register under bypass
      idle(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
      rd_en = 2'b11; rd_addr = {3'd0, 3'd0}; cyc();
      check("zero reg data", 32'(rd_data), 32'h0);
      check("zero reg wr_err", 32'(wr_err), 32'h0);

      // Out-of-range write
      do_write(3'd7, 16'h7777);
      check("oor wr_err set", 32'(wr_err), 32'h1);
      idle(); cyc();
      check("oor wr_err clear", 32'(wr_err), 32'h0);
      tbl[0] = 16'h0; tbl[1] = 16'h0; tbl[2] = 16'hA5A5;
      tbl[3] = 16'h0; tbl[4] = 16'h0; tbl[5] = 16'hBEEF;
      for (int a = 0; a < DEPTH; a++) begin
         do_read0(AW'(a));
         check($sformatf("oor keep addr%0d", a), 32'(rd_data[15:0]), 32'(tbl[a]));
      end
      do_read0(3'd7);
      check("oor read data", 32'(rd_data[15:0]), 32'h0);
      check("oor read valid", 32'(rd_valid[0]), 32'h1);

      // Clear wins over a concurrent write; same-cycle read returns 0
      for (int a = 0; a < DEPTH; a++) do_write(AW'(a), 16'h5555);
      do_read0(3'd4);
      check("fill addr4", 32'(rd_data[15:0]), 32'h5555);
      idle(); clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h9999;
      rd_en = 2'b10; rd_addr = {3'd4, 3'd0}; cyc();
      check("clr same-cycle read", 32'(rd_data[31:16]), 32'h0);
      for (int a = 0; a < DEPTH; a++) begin
         do_read0(AW'(a));
         check($sformatf("clr addr%0d", a), 32'(rd_data[15:0]), 32'h0);
      end

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         idle();
         clr     = ($urandom_range(0, 15) == 0);
         wr_en   = ($urandom_range(0, 2) != 0);
         wr_addr = clr ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 7));
         wr_data = WIDTH'($urandom);
         rd_en   = NUM_RD'($urandom);
         rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         if ($urandom_range(0, 3) == 0) rd_addr[5:3] = wr_addr;
         if ($urandom_range(0, 3) == 0) rd_addr[2:0] = wr_addr;
         if (n == 1000) begin
            #2 rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
         end else begin
            cyc();
         end
      end

      idle(); cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
